// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the frequency-to-divisor calculator.
// The dividend width doubles as the serial divider's iteration count.
package freq_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV,
      ST_STORE
   } state_t;

   localparam longint DEFAULT_CLK_HZ = 64'd50_000_000;

   // Width that holds CLK_HZ + f for every f representable in freq_w bits.
   function automatic int num_width(input longint clk_hz, input int freq_w);
      return $clog2(clk_hz + (longint'(1) << freq_w));
   endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per clock, MSB first, NUM_W steps.
// done is high during the cycle that performs the final step; quotient is valid the cycle after.
module serial_divider #(
   parameter int NUM_W = 27,
   parameter int DVS_W = 27
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [NUM_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [NUM_W-1:0] quotient,
   output logic             done
);

   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [DVS_W-1:0] rem;
   logic [DVS_W-1:0] dvs;
   logic [NUM_W-1:0] quo;
   logic [CNT_W-1:0] cnt;
   logic             active;

   logic [DVS_W:0]   trial;
   logic [DVS_W-1:0] diff;
   logic             fits;

   // The partial remainder stays below the divisor, so the low DVS_W bits of the difference are exact.
   always_comb begin
      trial = {rem, quo[NUM_W-1]};
      fits  = trial >= {1'b0, dvs};
      diff  = trial[DVS_W-1:0] - dvs;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rem    <= '0;
         dvs    <= '0;
         quo    <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         rem    <= '0;
         dvs    <= divisor;
         quo    <= dividend;
         cnt    <= CNT_W'(NUM_W);
         active <= 1'b1;
      end else if (active) begin
         rem <= fits ? diff : trial[DVS_W-1:0];
         quo <= {quo[NUM_W-2:0], fits};
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            active <= 1'b0;
         end
      end
   end

   assign quotient = quo;
   assign done     = active && (cnt == CNT_W'(1));

endmodule

// File: rtl/freq_div_calc.sv
// Multi-channel frequency-to-divisor calculator: DIV = floor((CLK_HZ + f) / (2f)),
// recomputed on FREQ change, channels served round-robin through one shared serial divider.
module freq_div_calc
   import freq_div_pkg::*;
#(
   parameter int     CHANNELS = 4,
   parameter int     FREQ_W   = 26,
   parameter int     DIV_W    = 26,
   parameter longint CLK_HZ   = DEFAULT_CLK_HZ
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS*FREQ_W-1:0] FREQ,
   output logic [CHANNELS*DIV_W-1:0]  DIV,
   output logic [CHANNELS-1:0]        DONE,
   output logic [CHANNELS-1:0]        ERR,
   output logic                       BUSY
);

   localparam int NUM_W = num_width(CLK_HZ, FREQ_W);
   localparam int DVS_W = FREQ_W + 1;
   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int CMP_W = (NUM_W > DIV_W) ? NUM_W : DIV_W;
   localparam logic [CMP_W-1:0] DIV_MAX = CMP_W'({DIV_W{1'b1}});

   logic [FREQ_W-1:0] freq_ch [CHANNELS];
   logic [FREQ_W-1:0] shadow  [CHANNELS];
   logic [DIV_W-1:0]  div_q   [CHANNELS];
   logic [CHANNELS-1:0] pend, changed, granted, err_q, done_q;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  last, cur, cand, gnt_idx;
   logic              gnt_valid, grant;
   logic [FREQ_W-1:0] gnt_freq, cur_freq;

   logic              div_start, div_done;
   logic [NUM_W-1:0]  dividend, quotient;
   logic [DVS_W-1:0]  divisor;
   logic [CMP_W-1:0]  q_ext;
   logic [DIV_W-1:0]  res_div;
   logic              res_err;

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      assign freq_ch[n]              = FREQ[n*FREQ_W +: FREQ_W];
      assign DIV[n*DIV_W +: DIV_W]   = div_q[n];
      assign changed[n]              = freq_ch[n] != shadow[n];
      assign granted[n]              = grant && (gnt_idx == IDX_W'(n));
   end

   // Round-robin search starting just after the last granted channel.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int off = 1; off <= CHANNELS; off++) begin
         cand = IDX_W'((int'(last) + off) % CHANNELS);
         if (!gnt_valid && pend[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign grant     = (state == ST_IDLE) && gnt_valid;
   assign gnt_freq  = freq_ch[gnt_idx];
   assign div_start = grant && (gnt_freq != '0);
   assign dividend  = NUM_W'(CLK_HZ) + NUM_W'(gnt_freq);
   assign divisor   = {gnt_freq, 1'b0};

   serial_divider #(
      .NUM_W (NUM_W),
      .DVS_W (DVS_W)
   ) u_div (
      .CLK      (CLK),
      .RST      (RST),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (divisor),
      .quotient (quotient),
      .done     (div_done)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (gnt_valid) state_nxt = (gnt_freq == '0) ? ST_STORE : ST_DIV;
         ST_DIV:   if (div_done) state_nxt = ST_STORE;
         ST_STORE: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Zero frequency and quotients beyond the output width are flagged as errors.
   always_comb begin
      q_ext   = CMP_W'(quotient);
      res_div = DIV_W'(q_ext);
      res_err = 1'b0;
      if (cur_freq == '0) begin
         res_div = '0;
         res_err = 1'b1;
      end else if (q_ext > DIV_MAX) begin
         res_div = '1;
         res_err = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= ST_IDLE;
         last     <= IDX_W'(CHANNELS - 1);
         cur      <= '0;
         cur_freq <= '0;
         pend     <= '1;
         done_q   <= '0;
         err_q    <= '0;
         // NOTE: the per-channel arrays are small and must reset, since shadow defines what counts as a change.
         for (int n = 0; n < CHANNELS; n++) begin
            shadow[n] <= '0;
            div_q[n]  <= '0;
         end
      end else begin
         state  <= state_nxt;
         done_q <= '0;
         pend   <= ~granted & (pend | changed);
         if (grant) begin
            cur             <= gnt_idx;
            last            <= gnt_idx;
            cur_freq        <= gnt_freq;
            shadow[gnt_idx] <= gnt_freq;
         end
         if (state == ST_STORE) begin
            div_q[cur]  <= res_div;
            err_q[cur]  <= res_err;
            done_q[cur] <= 1'b1;
         end
      end
   end

   assign DONE = done_q;
   assign ERR  = err_q;
   assign BUSY = state != ST_IDLE;

endmodule

// File: tb/tb_freq_div_calc.sv
// Directed bench for freq_div_calc: reset state, round-robin order, zero/saturation,
// mid-conversion change and mid-conversion reset, with hand-computed divisors.
module tb_freq_div_calc;

   localparam int FW = 26;

   typedef struct {
      int          ch;
      int          cyc;
      logic [25:0] dv;
      logic        er;
   } ev_t;

   logic         CLK = 1'b0;
   logic         RST;
   logic [103:0] FREQ;
   logic [103:0] DIV;
   logic [3:0]   DONE, ERR;
   logic         BUSY;

   logic [51:0]  FREQ8;
   logic [15:0]  DIV8;
   logic [1:0]   DONE8, ERR8;
   logic         BUSY8;

   int  cyc = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   ev_t evq[$];

   freq_div_calc #(
      .CHANNELS (4),
      .FREQ_W   (26),
      .DIV_W    (26),
      .CLK_HZ   (50_000_000)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .FREQ (FREQ),
      .DIV  (DIV),
      .DONE (DONE),
      .ERR  (ERR),
      .BUSY (BUSY)
   );

   freq_div_calc #(
      .CHANNELS (2),
      .FREQ_W   (26),
      .DIV_W    (8),
      .CLK_HZ   (50_000_000)
   ) dut8 (
      .CLK  (CLK),
      .RST  (RST),
      .FREQ (FREQ8),
      .DIV  (DIV8),
      .DONE (DONE8),
      .ERR  (ERR8),
      .BUSY (BUSY8)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      for (int n = 0; n < 4; n++) begin
         if (DONE[n] === 1'b1) evq.push_back('{ch: n, cyc: cyc, dv: DIV[n*FW +: FW], er: ERR[n]});
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_freq(input int ch, input logic [25:0] v);
      FREQ[ch*FW +: FW] = v;
   endtask

   task automatic wait_ev(input string tag, input int n, input int budget);
      int t = 0;
      while (evq.size() < n && t < budget) begin
         @(posedge CLK);
         t++;
      end
      @(negedge CLK);
      check({tag, "_count"}, evq.size(), n);
   endtask

   task automatic check_ev(input string tag, input int idx, input int ch, input int t,
                           input int dv, input bit er);
      if (idx < evq.size()) begin
         check($sformatf("%s%0d_ch", tag, idx), evq[idx].ch, ch);
         check($sformatf("%s%0d_cyc", tag, idx), evq[idx].cyc, t);
         check($sformatf("%s%0d_div", tag, idx), evq[idx].dv, dv);
         check($sformatf("%s%0d_err", tag, idx), evq[idx].er, er);
      end else begin
         check($sformatf("%s%0d_present", tag, idx), evq.size(), idx + 1);
      end
   endtask

   initial begin
      int c;
      int t;
      RST   = 1'b1;
      FREQ  = '0;
      FREQ8 = '0;
      set_freq(0, 3);
      set_freq(1, 128);
      set_freq(2, 115200);
      set_freq(3, 1);
      FREQ8[25:0]  = 26'd1;
      FREQ8[51:26] = 26'd200000;
      repeat (3) @(negedge CLK);
      check("rst_div", DIV, 0);
      check("rst_err", ERR, 0);
      check("rst_done", DONE, 0);
      check("rst_busy", BUSY, 0);

      // Power-up conversion of every channel in order 0..3.
      RST = 1'b0;
      c = cyc;
      wait_ev("boot", 4, 200);
      check_ev("boot", 0, 0, c + 29, 8333333, 0);
      check_ev("boot", 1, 1, c + 58, 195313, 0);
      check_ev("boot", 2, 2, c + 87, 217, 0);
      check_ev("boot", 3, 3, c + 116, 25000000, 0);
      check("boot_idle_busy", BUSY, 0);

      // Zero frequency: short path, error flag, single DONE.
      evq.delete();
      set_freq(2, 0);
      c = cyc;
      wait_ev("zero", 1, 60);
      check_ev("zero", 0, 2, c + 3, 0, 1);
      repeat (40) @(negedge CLK);
      check("zero_once", evq.size(), 1);

      // Make ch1 the last granted channel.
      evq.delete();
      set_freq(1, 115200);
      c = cyc;
      wait_ev("ch1", 1, 60);
      check_ev("ch1", 0, 1, c + 30, 217, 0);

      // All four change together: service order 2, 3, 0, 1.
      evq.delete();
      set_freq(0, 5);
      set_freq(1, 1);
      set_freq(2, 128);
      set_freq(3, 3);
      c = cyc;
      wait_ev("rr", 4, 200);
      check_ev("rr", 0, 2, c + 30, 195313, 0);
      check_ev("rr", 1, 3, c + 59, 8333333, 0);
      check_ev("rr", 2, 0, c + 88, 5000000, 0);
      check_ev("rr", 3, 1, c + 117, 25000000, 0);

      // ch0 changes while its own conversion is in progress.
      evq.delete();
      set_freq(0, 3);
      c = cyc;
      repeat (8) @(negedge CLK);
      check("mid_busy", BUSY, 1);
      set_freq(0, 5);
      wait_ev("mid", 2, 100);
      check_ev("mid", 0, 0, c + 30, 8333333, 0);
      check_ev("mid", 1, 0, c + 59, 5000000, 0);

      // Reset in the 10th divide cycle of ch3.
      evq.delete();
      set_freq(3, 1);
      c = cyc;
      repeat (12) @(negedge CLK);
      check("pre_rst_busy", BUSY, 1);
      RST = 1'b1;
      #1;
      check("arst_div", DIV, 0);
      check("arst_err", ERR, 0);
      check("arst_done", DONE, 0);
      check("arst_busy", BUSY, 0);
      check("arst_div8", DIV8, 0);
      repeat (2) @(negedge CLK);
      evq.delete();
      RST = 1'b0;
      c = cyc;
      wait_ev("reboot", 4, 200);
      check_ev("reboot", 0, 0, c + 29, 5000000, 0);
      check_ev("reboot", 1, 1, c + 58, 25000000, 0);
      check_ev("reboot", 2, 2, c + 87, 195313, 0);
      check_ev("reboot", 3, 3, c + 116, 25000000, 0);

      // 8-bit divisor instance: saturation on f=1, in range on f=200000.
      check("w8_sat_div", DIV8[7:0], 255);
      check("w8_sat_err", ERR8[0], 1);
      check("w8_ok_div", DIV8[15:8], 125);
      check("w8_ok_err", ERR8[1], 0);
      check("w8_idle_busy", BUSY8, 0);
      FREQ8[25:0] = 26'd200000;
      c = cyc;
      t = 0;
      while (DONE8[0] !== 1'b1 && t < 60) begin
         @(negedge CLK);
         t++;
      end
      check("w8_lat", cyc - c, 30);
      check("w8_new_div", DIV8[7:0], 125);
      check("w8_new_err", ERR8[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/freq_div_calc.md
# freq_div_calc

Parametrised multi-channel frequency-to-divisor calculator: converts requested output frequencies (Hz) into half-period divisor counts for the clock-divider/tone blocks, `DIV = round(CLK_HZ / (2*FREQ))`. Replaces fixed lookup tables with one shared serial restoring divider, so results are exact for every input value, not only tabulated ones. Channels are recomputed automatically when their input changes, served round-robin. Sits between the register/control logic that sets frequencies and the counter-based dividers that consume `DIV`.

## Interface
- `CHANNELS`, 4: number of independent frequency/divisor channels (1..16).
- `FREQ_W`, 26: width of each frequency input.
- `DIV_W`, 26: width of each divisor output.
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- Derived: `NUM_W = clog2(CLK_HZ + 2**FREQ_W)`, the dividend width and the iteration count (27 at defaults).

Ports:
- `CLK`  in  1  system clock; all state on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `FREQ`  in  CHANNELS*FREQ_W  packed frequencies; channel n at `[n*FREQ_W +: FREQ_W]`.
- `DIV`  out  CHANNELS*DIV_W  packed divisors, same packing.
- `DONE`  out  CHANNELS  one-cycle pulse when that channel's `DIV` and `ERR` update.
- `ERR`  out  CHANNELS  last conversion was `FREQ=0` or saturated.
- `BUSY`  out  1  divider not in IDLE.

## Operation
- Per channel: `shadow[n]` (last accepted FREQ), `pend[n]` (recompute request).
- Every edge: `pend[n] <= granted(n) ? 0 : pend[n] | (FREQ[n] != shadow[n])`.
- Quotient: `q = floor((CLK_HZ + f) / (2*f))`, equivalent to round-half-up of `CLK_HZ/(2f)`.
- FSM states:
  - IDLE: if any `pend`, grant the next pending channel at or after `last+1` (wrapping). Latch `f = FREQ[g]`, set `shadow[g] <= f`, `last <= g`. Go to DIV, or to STORE if `f == 0`.
  - DIV: one restoring step per cycle, MSB first, NUM_W cycles. Divisor is `2*f` (width FREQ_W+1).
  - STORE: write `DIV[g]`, `ERR[g]`, pulse `DONE[g]`, then go to IDLE.
- Result rules:
  - `f == 0`: `DIV = 0`, `ERR = 1`.
  - `q > 2**DIV_W - 1`: `DIV = all ones`, `ERR = 1`.
  - Otherwise: `DIV = q`, `ERR = 0`.
- A channel changing FREQ while it is being computed: `pend` is re-set against the new shadow, and the channel is recomputed after its current result is stored. The stale result is still written and `DONE` still pulses.
- Multiple changes to a channel before it is granted collapse into one conversion of the value present at grant.

## Timing
- Reset values:
  - `DIV` = 0, `ERR` = 0, `DONE` = 0, `BUSY` = 0.
  - `shadow` = 0, `pend` = all ones, so every channel converts after reset.
  - `last` = CHANNELS-1, so channel 0 is served first.
- Latency, FREQ change sampled at edge k on an idle block:
  - `pend` set at k.
  - Grant at k+1.
  - DIV occupies k+2..k+NUM_W+1.
  - STORE, `DIV`/`DONE` valid after edge k+NUM_W+2 (29 at defaults).
- Throughput: one conversion per NUM_W+2 cycles. `f == 0` takes 2 cycles (IDLE, STORE).
- `BUSY` is high from the grant edge through the STORE cycle.
- `RST` mid-operation: abort immediately to reset values. All channels are re-requested.

## Structure
- Package `freq_div_pkg`: FSM state enum (IDLE, DIV, STORE), `clog2`-based `num_width` function, default `CLK_HZ` constant.
- Sub-module `serial_divider`: parametrised by NUM_W and divisor width. Ports are start, dividend, divisor, quotient, done. No arbitration inside.
- Top level holds shadow/pend registers, the round-robin arbiter, output registers, and saturation/zero handling.

## Test plan
- After reset with FREQ = {3, 128, 115200, 1}: DONE order ch0..ch3, 29 cycles apart. DIV = {8333333, 195313, 217, 25000000}, ERR = 0.
- ch2 set to 0: 2 cycles after grant, DIV[2] = 0, ERR[2] = 1, DONE[2] pulses once.
- Change all four FREQ in the same cycle while ch1 was last granted: service order 2, 3, 0, 1.
- Change ch0 from 3 to 5 mid-DIV of ch0: DONE[0] with 8333333, then a second DONE[0] with 5000000 29 cycles later.
- DIV_W = 8, FREQ = 1: DIV = 255, ERR = 1. FREQ = 200000: DIV = 125, ERR = 0.
- Assert RST at DIV cycle 10: outputs return to reset values at once. After release, full reconversion starts with ch0 and no stale DONE appears.
